// File: rtl/pipe_if_id_fifo_pkg.sv
// Shared pipeline constants and small helpers for the IF/ID instruction queue.
package pipe_if_id_fifo_pkg;

   // Pipeline-wide bus widths (instruction address bus, instruction bus).
   localparam int INST_ADDR_BUS = 32;
   localparam int INST_BUS      = 32;

   // Bubble instruction presented to decode when nothing is queued: addi x0,x0,0.
   localparam logic [31:0] NOP_INST_C = 32'h0000_0013;

   // Stall vector layout: width and the bit that freezes the ID stage.
   localparam int STALL_W_C = 6;
   localparam int STALL_ID  = 2;

   // Queue operation performed at a clock edge, encoded as {push, pop}.
   typedef enum logic [1:0] {
      OP_HOLD = 2'b00,
      OP_POP  = 2'b01,
      OP_PUSH = 2'b10,
      OP_BOTH = 2'b11
   } fifo_op_e;

   // Classify the handshake outcome of one cycle.
   function automatic fifo_op_e fifo_op(input logic push, input logic pop);
      return fifo_op_e'({push, pop});
   endfunction

endpackage

// File: rtl/pipe_if_id_fifo_ctrl.sv
// Pointer and occupancy control for the IF/ID instruction queue.
// Decides push/pop from the handshake inputs and tracks wr_ptr, rd_ptr, count.
module pipe_if_id_fifo_ctrl
   import pipe_if_id_fifo_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_req,   // fetch offers an entry
   input  logic             id_stall,   // ID stage frozen this cycle
   input  logic             flush,      // branch redirect
   output logic             push,       // entry is written this cycle
   output logic             pop,        // head entry is consumed this cycle
   output logic             full,
   output logic             empty,
   output logic [PTR_W-1:0] wr_ptr,
   output logic [PTR_W-1:0] rd_ptr,
   output logic [CNT_W-1:0] count
);

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q,  count_d;

   // Status flags come straight from registered occupancy, so ready/valid
   // never depend combinationally on stall or br.
   assign full  = (count_q == CNT_W'(DEPTH));
   assign empty = (count_q == '0);

   // A redirect discards the concurrent fetch and blocks consumption.
   assign push = push_req & ~full  & ~flush;
   assign pop  = ~empty   & ~id_stall & ~flush;

   // Next-state for pointers and occupancy.
   always_comb begin
      // NOTE: every variable gets a default first, so no path can infer a latch.
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         // Everything queued is wrong-path: drop it by catching rd up to wr.
         count_d  = '0;
         rd_ptr_d = wr_ptr_q;
      end else begin
         // Pointers wrap naturally because DEPTH is a power of two.
         if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         case (fifo_op(push, pop))
            OP_PUSH: count_d = count_q + CNT_W'(1);
            OP_POP:  count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // State registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignment so every flop
         // samples the pre-edge values regardless of statement order.
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign wr_ptr = wr_ptr_q;
   assign rd_ptr = rd_ptr_q;
   assign count  = count_q;

   // Occupancy never exceeds capacity.
   a_count_bound : assert property (@(posedge clk) disable iff (rst)
      count_q <= CNT_W'(DEPTH));

   // Pointer distance always equals occupancy modulo DEPTH.
   a_ptr_count : assert property (@(posedge clk) disable iff (rst)
      (wr_ptr_q - rd_ptr_q) == count_q[PTR_W-1:0]);

endmodule

// File: rtl/pipe_if_id_fifo.sv
// IF/ID decoupling queue: DEPTH-entry {pc, inst} FIFO between fetch and decode.
// Fetch pushes on a valid/ready handshake, decode pops unless its stall bit is
// set, a branch redirect flushes the queue, and an empty queue shows a bubble.
module pipe_if_id_fifo
   import pipe_if_id_fifo_pkg::*;
#(
   parameter  int          ADDR_W       = INST_ADDR_BUS,
   parameter  int          INST_W       = INST_BUS,
   parameter  int          DEPTH        = 4,
   parameter  int          STALL_W      = STALL_W_C,
   parameter  int          ID_STALL_BIT = STALL_ID,
   parameter  logic [31:0] NOP_INST     = NOP_INST_C,
   localparam int          PTR_W        = $clog2(DEPTH),
   localparam int          CNT_W        = $clog2(DEPTH + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               if_valid,
   input  logic [ADDR_W-1:0]  if_pc,
   input  logic [INST_W-1:0]  if_inst,
   output logic               if_ready,
   input  logic [STALL_W-1:0] stall,
   input  logic               br,
   output logic               id_valid,
   output logic [ADDR_W-1:0]  id_pc,
   output logic [INST_W-1:0]  id_inst,
   output logic [CNT_W-1:0]   count,
   output logic               err_ovf
);

   localparam int ENTRY_W = ADDR_W + INST_W;

   logic             push;
   logic             pop;
   logic             full;
   logic             empty;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             err_ovf_q, err_ovf_d;
   logic [ENTRY_W-1:0] head;

   // Storage: one {pc, inst} pair per entry.
   logic [ENTRY_W-1:0] mem_q [DEPTH];

   // Only the ID stall bit matters here; the rest of the vector is ignored.
   logic stall_unused;
   assign stall_unused = ^stall;

   pipe_if_id_fifo_ctrl #(
      .DEPTH (DEPTH)
   ) u_fifo_ctrl (
      .clk      (clk),
      .rst      (rst),
      .push_req (if_valid),
      .id_stall (stall[ID_STALL_BIT]),
      .flush    (br),
      .push     (push),
      .pop      (pop),
      .full     (full),
      .empty    (empty),
      .wr_ptr   (wr_ptr),
      .rd_ptr   (rd_ptr),
      .count    (count)
   );

   // Write the accepted fetch entry at the write pointer.
   always_ff @(posedge clk) begin
      // NOTE: the data array has no reset; occupancy alone decides whether an
      // entry is meaningful, and unreset storage maps onto plain RAM cells.
      if (push) begin
         mem_q[wr_ptr] <= {if_pc, if_inst};
      end
   end

   // Sticky overflow: fetch offered an entry while the queue was full.
   always_comb begin
      err_ovf_d = err_ovf_q | (if_valid & full & ~br);
   end

   // Overflow flag register; cleared only by reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_ovf_q <= 1'b0;
      end else begin
         err_ovf_q <= err_ovf_d;
      end
   end

   // Show-ahead read of the head entry, replaced by a bubble when empty.
   assign head     = mem_q[rd_ptr];
   assign id_valid = ~empty;
   assign id_pc    = empty ? '0 : head[ENTRY_W-1:INST_W];
   assign id_inst  = empty ? INST_W'(NOP_INST) : head[INST_W-1:0];
   assign if_ready = ~full;
   assign err_ovf  = err_ovf_q;

   // A pop can only consume something that is present.
   a_pop_valid : assert property (@(posedge clk) disable iff (rst)
      pop |-> id_valid);

   // A push never lands on a full queue.
   a_push_ready : assert property (@(posedge clk) disable iff (rst)
      push |-> if_ready);

endmodule

// File: tb/tb_pipe_if_id_fifo.sv
// Self-checking bench for pipe_if_id_fifo: a queue-based reference model is
// updated by the stimulus at each edge; a negedge monitor compares every
// output against it and retires entries as decode consumes them.
module tb_pipe_if_id_fifo;

   localparam int          DEPTH = 4;
   localparam int          SID   = 2;
   localparam logic [31:0] NOP   = 32'h0000_0013;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
   } entry_t;

   logic        clk;
   logic        rst;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_inst;
   logic        if_ready;
   logic [5:0]  stall;
   logic        br;
   logic        id_valid;
   logic [31:0] id_pc;
   logic [31:0] id_inst;
   logic [2:0]  count;
   logic        err_ovf;

   entry_t exp_q[$];
   bit     ovf_m;
   int     n_tests;
   int     n_fail;

   pipe_if_id_fifo dut (
      .clk      (clk),
      .rst      (rst),
      .if_valid (if_valid),
      .if_pc    (if_pc),
      .if_inst  (if_inst),
      .if_ready (if_ready),
      .stall    (stall),
      .br       (br),
      .id_valid (id_valid),
      .id_pc    (id_pc),
      .id_inst  (id_inst),
      .count    (count),
      .err_ovf  (err_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one cycle of stimulus, then apply the model's view of that edge.
   task automatic step(input bit v, input logic [31:0] pc, input bit st, input bit b);
      logic [31:0] inst;
      bit acc;
      bit ovf;
      inst     = $urandom;
      if_valid = v;
      if_pc    = pc;
      if_inst  = inst;
      stall    = 6'($urandom);
      stall[SID] = st;
      br       = b;
      acc = v && !b && (exp_q.size() < DEPTH);
      ovf = v && !b && (exp_q.size() == DEPTH);
      @(posedge clk);
      if (b) exp_q.delete();
      else if (acc) exp_q.push_back('{pc: pc, inst: inst});
      if (ovf) ovf_m = 1'b1;
      #1;
   endtask

   task automatic idle_inputs();
      if_valid = 1'b0;
      if_pc    = '0;
      if_inst  = '0;
      stall    = '0;
      br       = 1'b0;
   endtask

   // Monitor: compare outputs to the model, retire the head on a decode pop.
   always @(negedge clk) begin
      if (!rst) begin
         check("mon_count",    64'(count),    64'(exp_q.size()));
         check("mon_if_ready", 64'(if_ready), 64'(exp_q.size() < DEPTH));
         check("mon_err_ovf",  64'(err_ovf),  64'(ovf_m));
         check("mon_id_valid", 64'(id_valid), 64'(exp_q.size() != 0));
         if (exp_q.size() != 0) begin
            check("mon_id_pc",   64'(id_pc),   64'(exp_q[0].pc));
            check("mon_id_inst", 64'(id_inst), 64'(exp_q[0].inst));
            if (!stall[SID] && !br) void'(exp_q.pop_front());
         end else begin
            check("mon_bubble_pc",   64'(id_pc),   64'd0);
            check("mon_bubble_inst", 64'(id_inst), 64'(NOP));
         end
      end
   end

   // Hard time limit so the run always terminates.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      n_tests = 0;
      n_fail  = 0;
      ovf_m   = 1'b0;
      idle_inputs();

      // 1. Reset then idle.
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      check("rst_id_valid", 64'(id_valid), 64'd0);
      check("rst_id_pc",    64'(id_pc),    64'd0);
      check("rst_id_inst",  64'(id_inst),  64'(NOP));
      check("rst_if_ready", 64'(if_ready), 64'd1);
      check("rst_count",    64'(count),    64'd0);
      check("rst_err_ovf",  64'(err_ovf),  64'd0);
      step(0, 32'h0, 0, 0);

      // 2. Fill under stall, then overflow attempt.
      for (int i = 0; i < 4; i++) step(1, 32'h100 + 32'(i * 4), 1, 0);
      check("fill_count",    64'(count),    64'd4);
      check("fill_if_ready", 64'(if_ready), 64'd0);
      check("fill_head_pc",  64'(id_pc),    64'h100);
      step(1, 32'h110, 1, 0);
      check("ovf_flag",  64'(err_ovf), 64'd1);
      check("ovf_count", 64'(count),   64'd4);
      check("ovf_head",  64'(id_pc),   64'h100);

      // 3. Drain in order on consecutive cycles.
      for (int i = 1; i < 4; i++) begin
         step(0, 32'h0, 0, 0);
         check("drain_pc", 64'(id_pc), 64'(32'h100 + 32'(i * 4)));
      end
      step(0, 32'h0, 0, 0);
      check("drain_empty_valid", 64'(id_valid), 64'd0);
      check("drain_empty_inst",  64'(id_inst),  64'(NOP));
      check("drain_empty_count", 64'(count),    64'd0);

      // 4. Streaming with wrap-around: one-cycle latency, no gaps.
      for (int i = 0; i < 10; i++) begin
         step(1, 32'(i * 4), 0, 0);
         check("stream_pc",    64'(id_pc),    64'(i * 4));
         check("stream_count", 64'(count),    64'd1);
      end
      step(0, 32'h0, 0, 0);
      check("stream_drained", 64'(id_valid), 64'd0);

      // 5. Flush with a concurrent wrong-path push.
      for (int i = 0; i < 3; i++) step(1, 32'h180 + 32'(i * 4), 1, 0);
      check("pre_flush_count", 64'(count), 64'd3);
      step(1, 32'h200, 1, 1);
      check("flush_count", 64'(count),    64'd0);
      check("flush_valid", 64'(id_valid), 64'd0);
      check("flush_inst",  64'(id_inst),  64'(NOP));
      step(1, 32'h300, 0, 0);
      check("post_flush_pc",    64'(id_pc),    64'h300);
      check("post_flush_valid", 64'(id_valid), 64'd1);
      step(0, 32'h0, 0, 0);

      // 6. Asynchronous reset mid-cycle.
      step(1, 32'h3A0, 1, 0);
      step(1, 32'h3A4, 1, 0);
      check("pre_rst_count", 64'(count), 64'd2);
      #2;
      rst = 1'b1;
      exp_q.delete();
      ovf_m = 1'b0;
      #1;
      check("async_rst_count", 64'(count),    64'd0);
      check("async_rst_valid", 64'(id_valid), 64'd0);
      check("async_rst_ovf",   64'(err_ovf),  64'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      step(1, 32'h400, 0, 0);
      check("after_rst_pc", 64'(id_pc), 64'h400);
      step(0, 32'h0, 0, 0);

      // Randomised traffic: pushes, stalls, occasional redirects.
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 3) != 0),
              ($urandom & 32'hFFFF_FFFC),
              ($urandom_range(0, 2) == 0),
              ($urandom_range(0, 15) == 0));
      end
      for (int i = 0; i < DEPTH + 1; i++) step(0, 32'h0, 0, 0);
      check("final_empty", 64'(count), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/pipe_if_id_fifo.md
Name: pipe_if_id_fifo

Overview:
Parametrised IF/ID decoupling stage that generalises the single-entry IF/ID pipeline register into a DEPTH-entry instruction queue of {pc, inst} pairs. Fetch pushes with a valid/ready handshake, and decode pops under control of the shared stall vector. A branch redirect (br) flushes every queued wrong-path entry. When the queue is empty, ID is presented with a NOP bubble.

Parameters:
ADDR_W, 32, PC width (matches `InstAddrBus)
INST_W, 32, instruction width (matches `InstBus)
DEPTH, 4, queue entries; power of two, >= 2
STALL_W, 6, width of pipeline stall vector
ID_STALL_BIT, 2, stall bit index that freezes the ID stage
NOP_INST, 32'h00000013, bubble instruction (addi x0,x0,0)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
if_valid  in  1  fetch presents a valid pc/inst this cycle
if_pc  in  ADDR_W  fetched PC
if_inst  in  INST_W  fetched instruction
if_ready  out  1  queue can accept a push (count != DEPTH)
stall  in  STALL_W  pipeline stall vector
br  in  1  branch redirect; flush the queue
id_valid  out  1  head entry is valid (count != 0)
id_pc  out  ADDR_W  head PC; 0 when empty
id_inst  out  INST_W  head instruction; NOP_INST when empty
count  out  $clog2(DEPTH+1)  current occupancy
err_ovf  out  1  sticky: push attempted while full

Behaviour:
- Single clock domain. Reset is asynchronous and active-high: wr_ptr=0, rd_ptr=0, count=0, err_ovf=0. Storage array is not reset.
- Reset output values: if_ready=1, id_valid=0, id_pc=0, id_inst=NOP_INST.
- push = if_valid & if_ready & ~br.
- pop = id_valid & ~stall[ID_STALL_BIT] & ~br.
- Push: mem[wr_ptr] <= {if_pc, if_inst}; wr_ptr increments modulo DEPTH, using natural wrap of the $clog2(DEPTH)-bit pointer.
- Pop: rd_ptr increments modulo DEPTH.
- Show-ahead read: id_pc/id_inst = mem[rd_ptr] when count != 0, else 0/NOP_INST. Outputs depend only on registered state, so there is no combinational path from stall, br or if_* to any output.
- Latency: an entry pushed at edge N is visible on id_* after edge N (one cycle, empty-queue case).
- count next-state:
  - push & ~pop: count+1
  - pop & ~push: count-1
  - both or neither: unchanged
- Simultaneous push and pop:
  - Legal whenever not full; occupancy is unchanged, and one entry per cycle streams through.
  - When full, if_ready=0 even if a pop occurs the same cycle (no ready-from-stall path), so throughput at full is DEPTH-1 per DEPTH cycles until the queue drains below full.
- Empty with stall deasserted: no pop; id_valid=0, bubble presented.
- Flush (br=1 at an edge):
  - count<=0 and rd_ptr<=wr_ptr.
  - Any concurrent if_valid entry is discarded (wrong path), and no pop occurs.
  - The cycle after the flush, id_valid=0 and id_inst=NOP_INST.
  - br has priority over stall.
- Overflow: if_valid & ~if_ready & ~br sets err_ovf=1. It is cleared only by rst. Queue state is unaffected.
- Reset asserted mid-operation: all state clears immediately (asynchronously) regardless of clk. The first push after reset deassertion lands in mem[0].
- Only stall[ID_STALL_BIT] is consumed; all other stall bits are ignored.

Decomposition:
- Shared defines: `InstAddrBus, `InstBus, the NOP_INST constant (`NopInst), and a stall-bit index constant (`StallId). All already belong in defines.v alongside the existing pipeline constants.
- One natural sub-module: fifo_ctrl. It is parametrised by DEPTH and owns wr_ptr, rd_ptr, count, full and empty.
- The data array and bubble mux stay in pipe_if_id_fifo.

Test Plan:
1. Reset then idle: rst=1 for 2 cycles, then release -> id_valid=0, id_pc=0, id_inst=32'h00000013, if_ready=1, count=0, err_ovf=0.
2. Fill under stall (DEPTH=4): stall[2]=1, push pc 0x100, 0x104, 0x108, 0x10C -> count=4, if_ready=0, id_pc=0x100 held. Then a 5th if_valid -> err_ovf=1, count stays 4.
3. Drain: release stall -> id_pc sequence 0x100, 0x104, 0x108, 0x10C on consecutive cycles. Then id_valid=0, id_inst=NOP, count=0.
4. Streaming plus wrap-around: continuous if_valid with pc 0x0..0x24 step 4, stall=0 -> one-cycle latency; id_pc follows if_pc delayed by 1 with no gaps; pointers wrap twice and all 10 entries appear in order.
5. Flush: 3 entries queued plus concurrent push of 0x200 with br=1 -> next cycle count=0, id_valid=0. A subsequent push of 0x300 appears at id_pc=0x300 one cycle later.
6. Reset mid-operation: 2 entries queued, rst asserted between clock edges -> count=0, id_valid=0 immediately, before the next edge. After release, a push of 0x400 is read back correctly.
